// File: rtl/i2c_bus_filter_if.sv
// Bus-side signal bundle for the I2C pin conditioning stage.
// master: the pin/consumer side; slave: the filter itself.
interface i2c_bus_filter_if;
    logic scl_raw;
    logic sda_raw;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic timeout;

    modport master (
        output scl_raw, sda_raw,
        input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
    );

    modport slave (
        input  scl_raw, sda_raw,
        output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
    );
endinterface

// File: rtl/i2c_bus_filter.sv
// I2C SDA/SCL synchroniser, glitch filter, edge/START/STOP detector and bus-busy tracker.
// Optional SCL-stuck-low watchdog enabled by defining I2C_FILTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer in progress (after reset, STOP or watchdog expiry)
// BUSY  | START seen, waiting for STOP (or watchdog expiry)
module i2c_bus_filter #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 1_250_000
) (
    input logic           clk,
    input logic           rst_n,
    i2c_bus_filter_if.slave bus
);

    localparam int             CW      = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // index 0 is SCL, index 1 is SDA
    logic [1:0]    raw;
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    filt;
    logic [1:0]    filt_d;
    logic [CW-1:0] cnt [2];

    state_t state;
    state_t state_nxt;
    logic   start_c;
    logic   stop_c;
    logic   timeout_c;

    assign raw = {bus.sda_raw, bus.scl_raw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 2'b11;
            sync   <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            meta   <= raw;
            sync   <= meta;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] != filt[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        filt[i] <= sync[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i]  <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // conditions only count with SCL stable high, so simultaneous SCL/SDA moves are ignored
    assign start_c = filt[0] & filt_d[0] & ~filt[1] &  filt_d[1];
    assign stop_c  = filt[0] & filt_d[0] &  filt[1] & ~filt_d[1];

`ifdef I2C_FILTER_TIMEOUT_EN
    localparam int            WW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_cnt;

    assign timeout_c = (state == BUSY) && !filt[0] && (wd_cnt == WD_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || (state != BUSY) || filt[0] || timeout_c) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
    assign timeout_c          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_c) state_nxt = BUSY;
            end
            BUSY: begin
                if (timeout_c || stop_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.scl_f     = filt[0];
    assign bus.sda_f     = filt[1];
    assign bus.scl_rise  = filt[0] & ~filt_d[0];
    assign bus.scl_fall  = ~filt[0] & filt_d[0];
    assign bus.start_det = start_c;
    assign bus.stop_det  = stop_c;
    assign bus.bus_busy  = (state == BUSY);
    assign bus.timeout   = timeout_c;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Scoreboard bench for i2c_bus_filter: directed bus scenarios plus random pin activity,
// each cycle checked against a pin-history reference model.
module tb_i2c_bus_filter;

    localparam int L     = 4;
    localparam int TB_TO = 100;

    typedef struct packed {
        logic scl_f;
        logic sda_f;
        logic rise;
        logic fall;
        logic start;
        logic stop;
        logic busy;
        logic to;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    i2c_bus_filter_if bus ();

    i2c_bus_filter #(
        .FILTER_LEN     (L),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_rise, n_fall, n_start, n_stop, n_to;

    // reference model: raw samples per edge, newest first
    bit hist_scl[$];
    bit hist_sda[$];
    bit f_scl, f_sda, p_scl, p_sda;
    bit m_busy, m_start, m_stop, m_to;
    int m_low;

    string names[8] = '{"timeout", "bus_busy", "stop_det", "start_det",
                        "scl_fall", "scl_rise", "sda_f", "scl_f"};

    // a line follows once its last L synchronised samples all disagree with it
    function automatic bit flips(input bit q[$], input bit cur);
        for (int k = 2; k <= L + 1; k++) begin
            if (q[k] == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit d);
        exp_t e;
        if (!r) begin
            hist_scl = {};
            hist_sda = {};
            for (int k = 0; k < L + 2; k++) begin
                hist_scl.push_back(1'b1);
                hist_sda.push_back(1'b1);
            end
            f_scl = 1'b1; f_sda = 1'b1; p_scl = 1'b1; p_sda = 1'b1;
            m_busy = 1'b0; m_start = 1'b0; m_stop = 1'b0; m_to = 1'b0;
            m_low = 0;
        end else begin
            if (m_stop || m_to) m_busy = 1'b0;
            if (m_start)        m_busy = 1'b1;
            hist_scl.push_front(s); void'(hist_scl.pop_back());
            hist_sda.push_front(d); void'(hist_sda.pop_back());
            p_scl = f_scl;
            p_sda = f_sda;
            if (flips(hist_scl, f_scl)) f_scl = ~f_scl;
            if (flips(hist_sda, f_sda)) f_sda = ~f_sda;
            m_start = f_scl & p_scl & ~f_sda & p_sda;
            m_stop  = f_scl & p_scl & f_sda & ~p_sda;
            m_to    = 1'b0;
`ifdef I2C_FILTER_TIMEOUT_EN
            if (m_busy && !f_scl) m_low++;
            else                  m_low = 0;
            if (m_low == TB_TO) begin
                m_to  = 1'b1;
                m_low = 0;
            end
`endif
        end
        e.scl_f = f_scl;
        e.sda_f = f_sda;
        e.rise  = f_scl & ~p_scl;
        e.fall  = ~f_scl & p_scl;
        e.start = m_start;
        e.stop  = m_stop;
        e.busy  = m_busy;
        e.to    = m_to;
        sb.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit d);
        @(negedge clk);
        rst_n       = r;
        bus.scl_raw = s;
        bus.sda_raw = d;
        model_step(r, s, d);
    endtask

    task automatic hold(input bit s, input bit d, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, s, d);
    endtask

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic zero_counts();
        n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_to = 0;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        logic [7:0] ev;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                ev  = e;
                act = {bus.scl_f, bus.sda_f, bus.scl_rise, bus.scl_fall,
                       bus.start_det, bus.stop_det, bus.bus_busy, bus.timeout};
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (act[i] !== ev[i]) begin
                        errors++;
                        $display("FAIL %s: got %b expected %b at %0t", names[i], act[i], ev[i], $time);
                    end
                end
                n_rise  += int'(bus.scl_rise === 1'b1);
                n_fall  += int'(bus.scl_fall === 1'b1);
                n_start += int'(bus.start_det === 1'b1);
                n_stop  += int'(bus.stop_det === 1'b1);
                n_to    += int'(bus.timeout === 1'b1);
            end
        end
    end

    initial begin : stimulus
        bit s, d;
        int n;
        bus.scl_raw = 1'b1;
        bus.sda_raw = 1'b1;
        zero_counts();

        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 20);

        // short SDA glitch is swallowed, a full-length one passes (and reads as START/STOP)
        hold(1'b1, 1'b0, 3);
        hold(1'b1, 1'b1, 12);
        hold(1'b1, 1'b0, 4);
        hold(1'b1, 1'b1, 12);

        // START then nine SCL clocks with data changing only while SCL is low
        hold(1'b1, 1'b0, 10);
        zero_counts();
        d = 1'b0;
        for (int i = 0; i < 9; i++) begin
            hold(1'b0, d, 10);
            d = 1'($urandom_range(0, 1));
            hold(1'b0, d, 15);
            hold(1'b1, d, 25);
        end
        hold(1'b1, d, 5);
        check_eq("clk_rises", n_rise, 9);
        check_eq("clk_falls", n_fall, 9);
        check_eq("clk_starts", n_start, 0);
        check_eq("clk_stops", n_stop, 0);

        // STOP, then START and a repeated START
        hold(1'b0, 1'b0, 10);
        hold(1'b1, 1'b0, 10);
        zero_counts();
        hold(1'b1, 1'b1, 10);
        check_eq("stop_count", n_stop, 1);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        zero_counts();
        hold(1'b1, 1'b0, 10);
        check_eq("rstart_count", n_start, 1);

        // SCL and SDA flipping together must not look like a condition
        zero_counts();
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b1, 10);
        check_eq("flip_starts", n_start, 0);
        check_eq("flip_stops", n_stop, 0);

        // SCL held low while busy
        zero_counts();
        hold(1'b0, 1'b0, 10000);
`ifdef I2C_FILTER_TIMEOUT_EN
        check_eq("timeouts", n_to, 1);
`else
        check_eq("timeouts", n_to, 0);
`endif

        // reset in the middle of a transfer with SCL low
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 20);
        cyc(1'b0, 1'b0, 1'b0);
        zero_counts();
        hold(1'b1, 1'b1, 20);
        check_eq("post_rst_rises", n_rise, 0);
        check_eq("post_rst_stops", n_stop, 0);

        // random pin activity, including sub-filter glitches and occasional resets
        for (int b = 0; b < 800; b++) begin
            if ($urandom_range(0, 99) == 0) begin
                cyc(1'b0, 1'b1, 1'b1);
            end else begin
                s = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
                n = $urandom_range(1, 12);
                hold(s, d, n);
            end
        end
        hold(1'b1, 1'b1, 10);

        @(posedge clk);
        #2;
        check_eq("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_bus_filter.md
# i2c_bus_filter

Front-end conditioning stage that sits between the SDA/SCL GPIO pins and the I2C subordinate logic. Samples the raw open-drain lines on the 50 MHz system clock, synchronises them, rejects glitches shorter than a programmable number of cycles, and produces clean levels, single-cycle SCL edge strobes, START/STOP strobes, and a bus-busy flag. The downstream subordinate logic consumes `scl_f`/`sda_f` instead of the raw pins. An optional watchdog releases the busy flag if SCL is stuck low.

## Interface
Parameters:
- `FILTER_LEN`, default 4: consecutive cycles a synchronised line must differ from its filtered value before the filtered value follows. Legal range ≥1.
- `TIMEOUT_CYCLES`, default 1_250_000: SCL-low watchdog limit, 25 ms at 50 MHz. Used only with the macro. Legal range ≥2.

Ports:
- `clk` in 1: system clock (CLOCK_50). This is the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `scl_raw` in 1: raw SCL pin level (asynchronous).
- `sda_raw` in 1: raw SDA pin level (asynchronous).
- `scl_f` out 1: filtered SCL level.
- `sda_f` out 1: filtered SDA level.
- `scl_rise` out 1: one-cycle pulse in the first cycle `scl_f` is 1 after being 0.
- `scl_fall` out 1: one-cycle pulse in the first cycle `scl_f` is 0 after being 1.
- `start_det` out 1: one-cycle pulse when a START or repeated START occurs.
- `stop_det` out 1: one-cycle pulse when a STOP occurs.
- `bus_busy` out 1: high from a START until a STOP or a timeout.
- `timeout` out 1: one-cycle pulse when the watchdog expires. Tied to 0 when the macro is absent.

## Operation
Synchroniser:
- Each line passes through a 2-flop synchroniser.
- Both flops reset to 1, the idle bus level.

Glitch filter, per line, with an independent counter `cnt` of width clog2(FILTER_LEN+1):
- If sync ≠ filtered and `cnt` = FILTER_LEN-1: filtered takes the sync value and `cnt` is set to 0.
- Else if sync ≠ filtered: `cnt` increments.
- Else: `cnt` is set to 0, so a pulse shorter than FILTER_LEN cycles is discarded entirely.
- Reset: `cnt` = 0; `scl_f` = `sda_f` = 1.

Edge and condition detection:
- `scl_d` and `sda_d` are registered copies of `scl_f` and `sda_f`; both reset to 1.
- `scl_rise` = `scl_f` & ~`scl_d`.
- `scl_fall` = ~`scl_f` & `scl_d`.
- `start_det` = `scl_f` & `scl_d` & ~`sda_f` & `sda_d`, i.e. SDA falls while SCL is stable high.
- `stop_det` = `scl_f` & `scl_d` & `sda_f` & ~`sda_d`.
- If SCL and SDA change in the same cycle, neither `start_det` nor `stop_det` fires.

Bus state machine, states IDLE and BUSY, reset to IDLE:
- IDLE → BUSY on `start_det`.
- BUSY → BUSY on `start_det` (repeated start); the pulse is still emitted.
- BUSY → IDLE on `stop_det`.
- BUSY → IDLE on watchdog expiry (macro only).
- `stop_det` in IDLE is pulsed and leaves the state unchanged.
- `bus_busy` is a registered output equal to (state == BUSY).

Reset:
- Every output is 0 during reset, except `scl_f` and `sda_f`, which are 1.
- Asserting reset mid-transfer returns the block to IDLE within one edge.
- No strobe is emitted on the first cycle after reset is released.

## Timing
- Raw to filtered latency, with the raw level stable: `scl_f`/`sda_f` change on the (FILTER_LEN+2)th rising `clk` edge after the raw transition. With the default, that is the 6th edge.
- Strobes are asserted combinationally in the same cycle as the filtered change and last exactly one cycle.
- `bus_busy` rises one cycle after `start_det` and falls one cycle after `stop_det` or `timeout`.
- Minimum resolvable SCL high or low time: FILTER_LEN cycles (80 ns at the default).

## Configuration
Macro `I2C_FILTER_TIMEOUT_EN`.

Defined:
- A counter of width clog2(TIMEOUT_CYCLES) runs while state == BUSY and `scl_f` == 0.
- The counter clears on any cycle with `scl_f` == 1, and in IDLE.
- When the count reaches TIMEOUT_CYCLES-1: `timeout` pulses for one cycle, the state goes to IDLE, and the counter clears.
- If `timeout` and `stop_det` coincide, the result is IDLE with both pulses.

Undefined:
- No counter is built, `timeout` is constant 0, and BUSY is left only by STOP or reset.

## Test plan
1. Reset release with both raw lines at 1 → `scl_f` = `sda_f` = 1 and all strobes, `bus_busy` and `timeout` at 0 for 20 cycles.
2. With FILTER_LEN = 4, drive `sda_raw` low for 3 cycles and then back high → `sda_f` stays 1 throughout. A 4-cycle low pulse → `sda_f` goes low on edge 6 and back high 6 edges after the release.
3. With SCL high, drop SDA → `start_det` pulses once and `bus_busy` = 1 on the next cycle. Then toggle SCL 9 times with a 25-cycle half-period → exactly 9 `scl_rise` and 9 `scl_fall` pulses, with no `start_det` or `stop_det`.
4. Raise SDA while SCL is high → `stop_det` pulses and `bus_busy` returns to 0. Issue a repeated START while busy → `start_det` pulses and `bus_busy` stays 1. Flip SCL and SDA in the same cycle → no condition strobe.
5. With the macro defined and TIMEOUT_CYCLES = 100, START and then hold SCL low → `timeout` pulses once, exactly 100 cycles after `scl_f` falls, and `bus_busy` drops next cycle. Without the macro, `bus_busy` stays 1 after 10 000 cycles.
6. Assert `rst_n` low during BUSY with SCL low → on the next edge `bus_busy` = 0, `scl_f` = 1, and no strobes. After release with the raw lines high, no spurious `scl_rise` or `stop_det`.
